// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared types for the LC-3b I/D memory arbiter: word and mask types plus the arbiter state encoding.
package pipeline_mem_arbiter_pkg;

    localparam int LC3B_WORD_W = 16;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;
    typedef logic [1:0]             lc3b_mem_wmask;

    typedef enum logic [2:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        I_RESP,
        D_RESP
    } arb_state_t;

endpackage

// File: rtl/pipeline_mem_arbiter_register.sv
// Loadable capture register with synchronous active-high clear.
module pipeline_mem_arbiter_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Serialises LC-3b fetch and MEM-stage requests onto one physical memory port,
// returning a one-cycle resp with the captured read word.
module pipeline_mem_arbiter
    import pipeline_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  lc3b_mem_wmask     d_mem_byte_enable,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output lc3b_mem_wmask     pmem_byte_enable,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        lc3b_mem_wmask     be;
        logic              wr;
    } grant_t;

    arb_state_t        state, state_next;
    grant_t            gnt_d, gnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              abandon_q, abandon_ld;
    logic              i_req, d_req, pick_d, grant, busy, owner_req;

    assign i_req     = i_mem_read;
    assign d_req     = d_mem_read | d_mem_write;
    assign pick_d    = d_req && (!i_req || D_PRIORITY);
    assign grant     = (state == IDLE) && (i_req || d_req);
    assign busy      = (state == I_BUSY) || (state == D_BUSY);
    assign owner_req = (state == I_BUSY) ? i_req : d_req;

    // Abandon clears on every grant and sets if the owner drops its request mid-access.
    assign abandon_ld = grant || (busy && !owner_req);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        gnt_d      = '0;
        if (pick_d) begin
            gnt_d.addr  = d_mem_address;
            gnt_d.wdata = d_mem_wdata;
            gnt_d.wr    = d_mem_write;
            gnt_d.be    = d_mem_write ? d_mem_byte_enable : 2'b11;
        end else begin
            gnt_d.addr  = i_mem_address;
            gnt_d.be    = 2'b11;
        end
        case (state)
            IDLE:    if (grant) state_next = pick_d ? D_BUSY : I_BUSY;
            I_BUSY:  if (pmem_resp) state_next = I_RESP;
            D_BUSY:  if (pmem_resp) state_next = D_RESP;
            default: state_next = IDLE;
        endcase
    end

    pipeline_mem_arbiter_register #(.WIDTH($bits(grant_t))) u_gnt (
        .clk   (clk),
        .reset (reset),
        .load  (grant),
        .d     (gnt_d),
        .q     (gnt_q)
    );

    pipeline_mem_arbiter_register #(.WIDTH(DATA_W)) u_rdata (
        .clk   (clk),
        .reset (reset),
        .load  (busy && pmem_resp),
        .d     (pmem_rdata),
        .q     (rdata_q)
    );

    pipeline_mem_arbiter_register #(.WIDTH(1)) u_abandon (
        .clk   (clk),
        .reset (reset),
        .load  (abandon_ld),
        .d     (!grant),
        .q     (abandon_q)
    );

    always_comb begin
        pmem_read        = busy && !gnt_q.wr;
        pmem_write       = busy && gnt_q.wr;
        pmem_byte_enable = gnt_q.be;
        pmem_address     = gnt_q.addr;
        pmem_wdata       = gnt_q.wdata;
        i_mem_resp       = (state == I_RESP) && !abandon_q;
        d_mem_resp       = (state == D_RESP) && !abandon_q;
        i_mem_rdata      = ((state == I_RESP) && !abandon_q) ? rdata_q : '0;
        d_mem_rdata      = ((state == D_RESP) && !abandon_q) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Bench for pipeline_mem_arbiter: core-side request driver, wait-state pmem model, word-level reference memory.
module tb_pipeline_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_mem_read = 1'b0, d_mem_read = 1'b0, d_mem_write = 1'b0;
    logic [15:0] i_mem_address = '0, d_mem_address = '0, d_mem_wdata = '0;
    logic [1:0]  d_mem_byte_enable = '0;
    logic [15:0] i_mem_rdata, d_mem_rdata, pmem_address, pmem_wdata;
    logic        i_mem_resp, d_mem_resp, pmem_read, pmem_write;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata = '0;
    logic        pmem_resp = 1'b0;

    pipeline_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_byte_enable(d_mem_byte_enable), .d_mem_address(d_mem_address),
        .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_byte_enable(pmem_byte_enable),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] wd;
        int          len;
    } acc_t;

    acc_t        log_q[$];
    logic [15:0] pm  [bit [15:0]];
    logic [15:0] rm  [bit [15:0]];
    int          checks = 0, failures = 0;
    int          pm_wait = 0, wcnt = 0, unstable = 0, leak = 0;
    int          i_resp_n = 0, d_resp_n = 0, exp_i_tot = 0, exp_d_tot = 0;
    logic [15:0] st_addr = '0, st_wd = '0;

    function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] wd, logic [1:0] be);
        return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
    endfunction
    function automatic logic [15:0] dflt(logic [15:0] a);
        return (a & 16'hFFFE) ^ 16'hA5C3;
    endfunction
    function automatic logic [15:0] pm_rd(logic [15:0] a);
        return pm.exists(a & 16'hFFFE) ? pm[a & 16'hFFFE] : dflt(a);
    endfunction
    function automatic void pm_wr(logic [15:0] a, logic [15:0] wd, logic [1:0] be);
        pm[a & 16'hFFFE] = merge(pm_rd(a), wd, be);
    endfunction
    function automatic logic [15:0] ref_rd(logic [15:0] a);
        return rm.exists(a & 16'hFFFE) ? rm[a & 16'hFFFE] : dflt(a);
    endfunction
    function automatic void ref_wr(logic [15:0] a, logic [15:0] wd, logic [1:0] be);
        rm[a & 16'hFFFE] = merge(ref_rd(a), wd, be);
    endfunction

    // Physical memory: answers after pm_wait strobe cycles, logs every completed access.
    always @(negedge clk) begin
        pmem_resp  <= (pmem_read || pmem_write) && (wcnt >= pm_wait);
        pmem_rdata <= pmem_read ? pm_rd(pmem_address) : 16'h0;
    end

    always @(posedge clk) begin
        if (pmem_read || pmem_write) begin
            if (wcnt == 0) begin
                st_addr <= pmem_address;
                st_wd   <= pmem_wdata;
            end else if (pmem_address !== st_addr || pmem_wdata !== st_wd)
                unstable <= unstable + 1;
            if (pmem_resp) begin
                if (pmem_write) pm_wr(pmem_address, pmem_wdata, pmem_byte_enable);
                log_q.push_back('{pmem_address, pmem_write, pmem_byte_enable, pmem_wdata, wcnt + 1});
                wcnt <= 0;
            end else
                wcnt <= wcnt + 1;
        end else
            wcnt <= 0;
    end

    always @(negedge clk) begin
        if (i_mem_resp) i_resp_n <= i_resp_n + 1;
        if (d_mem_resp) d_resp_n <= d_resp_n + 1;
        leak <= leak + ((!i_mem_resp && i_mem_rdata !== 16'h0) ? 1 : 0)
                     + ((!d_mem_resp && d_mem_rdata !== 16'h0) ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_acc(input string tag, input logic [15:0] a, input bit wr,
                           input logic [1:0] be, input logic [15:0] wd);
        acc_t e;
        chk({tag, "_logged"}, log_q.size() != 0, 1);
        if (log_q.size() == 0) return;
        e = log_q.pop_front();
        chk({tag, "_addr"}, e.addr, a);
        chk({tag, "_wr"}, e.wr, wr);
        chk({tag, "_be"}, e.be, be);
        if (wr) chk({tag, "_wdata"}, e.wd, wd);
        chk({tag, "_len"}, e.len, pm_wait + 1);
    endtask

    // Core-side driver: raise requests, hold until resp, drop the cycle after resp.
    task automatic do_req(input bit i_en, input logic [15:0] ia, input bit d_en, input bit dw,
                          input logic [15:0] da, input logic [15:0] dwd, input logic [1:0] dbe,
                          input bit mutate, input bit squash,
                          output int i_lat, output int d_lat, output logic [15:0] i_rd,
                          output logic [15:0] d_rd, output bit d_first);
        int cyc;
        bit i_pend, d_pend;
        cyc = 0; i_pend = i_en; d_pend = d_en;
        i_lat = -1; d_lat = -1; i_rd = '0; d_rd = '0; d_first = 0;
        i_mem_read = i_en; i_mem_address = ia;
        d_mem_read = d_en && !dw; d_mem_write = d_en && dw;
        d_mem_address = da; d_mem_wdata = dwd; d_mem_byte_enable = dbe;
        while ((i_pend || d_pend) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (i_pend && i_mem_resp) begin i_pend = 0; i_lat = cyc; i_rd = i_mem_rdata; end
            if (d_pend && d_mem_resp) begin d_pend = 0; d_lat = cyc; d_rd = d_mem_rdata; d_first = i_pend; end
            step();
            if (cyc == 1 && mutate) begin
                i_mem_address = ia ^ 16'h0100; d_mem_address = da ^ 16'h0100;
                d_mem_wdata = ~dwd; d_mem_byte_enable = ~dbe;
            end
            if (cyc == 2 && squash) i_pend = 0;
            if (!i_pend) i_mem_read = 0;
            if (!d_pend) begin d_mem_read = 0; d_mem_write = 0; end
        end
        i_mem_read = 0; d_mem_read = 0; d_mem_write = 0;
    endtask

    task automatic op(input bit ie, input logic [15:0] ia, input bit de, input bit dw,
                      input logic [15:0] da, input logic [15:0] wd, input logic [1:0] be,
                      input bit mut, output int il, output int dl);
        logic [15:0] ir, dr, ei, ed;
        bit df;
        ei = ref_rd(ia);
        ed = ref_rd(da);
        do_req(ie, ia, de, dw, da, wd, be, mut, 1'b0, il, dl, ir, dr, df);
        if (de && dw) ref_wr(da, wd, be);
        exp_i_tot += int'(ie);
        exp_d_tot += int'(de);
        if (ie) begin chk("i_done", il > 0, 1); chk("i_rdata", ir, ei); end
        if (de) begin
            chk("d_done", dl > 0, 1);
            if (!dw) chk("d_rdata", dr, ed);
            chk_acc("d_acc", da, dw, dw ? be : 2'b11, wd);
        end
        if (ie && de) chk("d_first", df, 1);
        if (ie) chk_acc("i_acc", ia, 1'b0, 2'b11, 16'h0);
    endtask

    initial begin
        int il, dl, cnt;
        logic [15:0] ir, dr, ia, da, wd;
        logic [1:0] be;
        bit df, seen, ie, de, dw, mut;
        int kind;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_be", pmem_byte_enable, 0);
        chk("rst_pmem_addr", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_i_resp", i_mem_resp, 0);
        chk("rst_d_resp", d_mem_resp, 0);
        chk("rst_i_rdata", i_mem_rdata, 0);
        chk("rst_d_rdata", d_mem_rdata, 0);
        step();
        reset = 0;

        pm[16'h3000] = 16'h1234; rm[16'h3000] = 16'h1234;
        pm_wait = 0;
        op(1, 16'h3000, 0, 0, 16'h0, 16'h0, 2'b00, 0, il, dl);
        chk("i_first_latency", il, 3);

        pm_wait = 3;
        op(0, 16'h0, 1, 1, 16'h4002, 16'hBEEF, 2'b10, 0, il, dl);
        pm_wait = 1;
        op(0, 16'h0, 1, 0, 16'h4002, 16'h0, 2'b00, 0, il, dl);
        op(1, 16'h3002, 1, 0, 16'h5000, 16'h0, 2'b00, 0, il, dl);

        // Fetch squashed while its physical read is in flight.
        pm_wait = 3;
        cnt = i_resp_n;
        do_req(1, 16'h3004, 0, 0, 16'h0, 16'h0, 2'b00, 0, 1, il, dl, ir, dr, df);
        repeat (8) step();
        chk("squash_no_resp", i_resp_n, cnt);
        chk_acc("squash_acc", 16'h3004, 0, 2'b11, 16'h0);

        // Reset while D_BUSY.
        pm_wait = 5;
        cnt = d_resp_n;
        d_mem_read = 1; d_mem_address = 16'h6000;
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin @(negedge clk); seen = pmem_read; end
        chk("rst_busy_strobe", seen, 1);
        step();
        reset = 1; d_mem_read = 0;
        step();
        reset = 0;
        @(negedge clk);
        chk("rst_busy_read_drop", pmem_read, 0);
        chk("rst_busy_addr", pmem_address, 0);
        repeat (8) step();
        chk("rst_busy_no_resp", d_resp_n, cnt);
        chk("rst_busy_no_access", log_q.size(), 0);
        pm_wait = 0;
        op(0, 16'h0, 1, 0, 16'h6000, 16'h0, 2'b00, 0, il, dl);

        pm_wait = 3;
        op(1, 16'h3000, 0, 0, 16'h0, 16'h0, 2'b00, 1, il, dl);

        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 2));
            ie = (kind != 1); de = (kind != 0); dw = 1'(($urandom_range(0, 1)));
            ia = 16'h3000 | 16'($urandom_range(0, 127) << 1);
            da = 16'h4000 | 16'($urandom_range(0, 15) << 1);
            wd = 16'($urandom);
            be = 2'($urandom_range(1, 3));
            mut = (kind != 2) && ($urandom_range(0, 1) == 1);
            pm_wait = int'($urandom_range(0, 3));
            op(ie, ia, de, dw, da, wd, be, mut, il, dl);
            if ($urandom_range(0, 1) == 1) step();
        end

        repeat (3) step();
        chk("i_resp_total", i_resp_n, exp_i_tot);
        chk("d_resp_total", d_resp_n, exp_d_tot);
        chk("rdata_outside_resp", leak, 0);
        chk("pmem_held_stable", unstable, 0);
        chk("no_extra_access", log_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
